// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - command-to-ALU sequencer with in-order flagged response FIFO
//
// Registers accepted {op, a, b} commands onto an external combinational ALU,
// captures the ALU result on the following edge together with Z/V/N flags, and
// buffers results in a small FIFO that drains over a valid/ready response port.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_a, cmd_b          command opcode (00 ADD, 01 SUB, 10 NAND, 11 XOR) and operands
//   alu_op, alu_in1, alu_in2      registered drive to the ALU
//   alu_out, alu_err              ALU result and signed-overflow indication
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_flags           FIFO head result and flags {Z,V,N}
module alu_cmd_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_flags
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW+1:0] OCC_LIMIT = (PW+2)'(DEPTH);

  logic             exec_vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [2:0]       flag_mem [DEPTH];

  logic             cmd_accept;
  logic             push;
  logic             pop;
  logic [PW+1:0]    occupancy;
  logic [2:0]       push_flags;

  // The EXEC entry is counted as already occupying a FIFO slot, so a result
  // leaving EXEC always finds room and no stall path is needed.
  assign occupancy  = {1'b0, count} + {{(PW+1){1'b0}}, exec_vld};
  assign cmd_ready  = occupancy < OCC_LIMIT;
  assign cmd_accept = cmd_valid & cmd_ready;
  assign push       = exec_vld;
  assign rsp_valid  = (count != '0);
  assign pop        = rsp_valid & rsp_ready;

  // Overflow only has meaning for ADD/SUB (op[1] = 0); logic ops mask it.
  always_comb begin
    push_flags    = 3'b000;
    push_flags[2] = (alu_out == '0);
    push_flags[1] = alu_err & ~alu_op[1];
    push_flags[0] = alu_out[WIDTH-1];
  end

  assign rsp_data  = data_mem[rd_ptr];
  assign rsp_flags = flag_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_vld <= 1'b0;
      alu_op   <= '0;
      alu_in1  <= '0;
      alu_in2  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        flag_mem[i] <= '0;
      end
    end else begin
      // ALU inputs only move on accept so the ALU sees stable operands.
      if (cmd_accept) begin
        alu_op   <= cmd_op;
        alu_in1  <= cmd_a;
        alu_in2  <= cmd_b;
        exec_vld <= 1'b1;
      end else begin
        exec_vld <= 1'b0;
      end

      if (push) begin
        data_mem[wr_ptr] <= alu_out;
        flag_mem[wr_ptr] <= push_flags;
        wr_ptr           <= wr_ptr + PW'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - self-checking bench for alu_cmd_ctrl
module tb_alu_cmd_ctrl;

  localparam int W     = 4;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = '0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_in2;
  logic [W-1:0] alu_out;
  logic         alu_err;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic [2:0]   rsp_flags;

  always #5 clk = ~clk;

  alu_cmd_ctrl #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_err(alu_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags)
  );

  // Environment ALU. For logic ops the overflow line carries junk on purpose.
  always_comb begin
    alu_out = '0;
    alu_err = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_out = alu_in1 + alu_in2;
        alu_err = (alu_in1[W-1] == alu_in2[W-1]) && (alu_out[W-1] != alu_in1[W-1]);
      end
      2'b01: begin
        alu_out = alu_in1 - alu_in2;
        alu_err = (alu_in1[W-1] != alu_in2[W-1]) && (alu_out[W-1] != alu_in1[W-1]);
      end
      2'b10: begin
        alu_out = ~(alu_in1 & alu_in2);
        alu_err = ^alu_in1;
      end
      default: begin
        alu_out = alu_in1 ^ alu_in2;
        alu_err = 1'b1;
      end
    endcase
  end

  typedef struct {
    logic [W-1:0] d;
    logic [2:0]   f;
    int           acc_edge;
  } rsp_t;

  rsp_t         exp_q[$];
  logic [W-1:0] pop_d[$];
  logic [2:0]   pop_f[$];
  int           ecnt = 0;
  logic [1:0]   last_op = '0;
  logic [W-1:0] last_a = '0;
  logic [W-1:0] last_b = '0;
  bit           rand_rdy = 1'b0;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed arithmetic on integers, result reduced modulo 16.
  function automatic rsp_t ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    rsp_t r;
    int   sa, sb, full;
    sa = a[W-1] ? int'(a) - 16 : int'(a);
    sb = b[W-1] ? int'(b) - 16 : int'(b);
    r.f = 3'b000;
    case (op)
      2'b00: begin full = sa + sb; r.d = W'((int'(a) + int'(b)) % 16); r.f[1] = (full > 7) || (full < -8); end
      2'b01: begin full = sa - sb; r.d = W'((int'(a) - int'(b) + 16) % 16); r.f[1] = (full > 7) || (full < -8); end
      2'b10: r.d = ~(a & b);
      default: r.d = a ^ b;
    endcase
    r.f[2] = (r.d == '0);
    r.f[0] = r.d[W-1];
    r.acc_edge = 0;
    return r;
  endfunction

  task automatic tick(output bit acc);
    bit   pop;
    logic exp_v;
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_q.size() < DEPTH));
    exp_v = (exp_q.size() > 0) && (ecnt >= exp_q[0].acc_edge + 1);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].d));
      chk("rsp_flags", 32'(rsp_flags), 32'(exp_q[0].f));
    end
    chk("alu_op", 32'(alu_op), 32'(last_op));
    chk("alu_in1", 32'(alu_in1), 32'(last_a));
    chk("alu_in2", 32'(alu_in2), 32'(last_b));
    acc = cmd_valid & cmd_ready;
    pop = rsp_valid & rsp_ready;
    if (pop) begin
      pop_d.push_back(rsp_data);
      pop_f.push_back(rsp_flags);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (acc) begin
      rsp_t r;
      r = ref_model(cmd_op, cmd_a, cmd_b);
      r.acc_edge = ecnt + 1;
      exp_q.push_back(r);
      last_op = cmd_op;
      last_a  = cmd_a;
      last_b  = cmd_b;
    end
    @(posedge clk);
    ecnt++;
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      tick(acc);
      n++;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'(1));
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      tick(acc);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_op = '0; last_a = '0; last_b = '0;
  endtask

  initial begin
    bit acc;
    int n;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("reset_rsp_data", 32'(rsp_data), 32'(0));
    chk("reset_rsp_flags", 32'(rsp_flags), 32'(0));
    chk("reset_alu_in1", 32'(alu_in1), 32'(0));

    // Reset mid-flight: accepted ADD must be discarded
    rsp_ready = 1'b1;
    send(2'b00, 4'h3, 4'h4);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("midrst_alu_in1", 32'(alu_in1), 32'(0));
    @(posedge clk);
    ecnt++;
    #1 rst = 1'b0;
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'(1));
    repeat (3) tick(acc);
    chk("midrst_no_rsp", 32'(pop_d.size()), 32'(0));

    // Single ADD
    pop_d.delete(); pop_f.delete();
    send(2'b00, 4'h3, 4'h4);
    drain();
    chk("add_count", 32'(pop_d.size()), 32'(1));
    if (pop_d.size() == 1) begin
      chk("add_data", 32'(pop_d[0]), 32'(4'h7));
      chk("add_flags", 32'(pop_f[0]), 32'(3'b000));
    end

    // Overflow / SUB / XOR zero
    pop_d.delete(); pop_f.delete();
    send(2'b00, 4'h7, 4'h1);
    send(2'b01, 4'h8, 4'h1);
    send(2'b11, 4'h5, 4'h5);
    drain();
    chk("ovf_count", 32'(pop_d.size()), 32'(3));
    if (pop_d.size() == 3) begin
      chk("ovf_add_data", 32'(pop_d[0]), 32'(4'h8));
      chk("ovf_add_flags", 32'(pop_f[0]), 32'(3'b011));
      chk("ovf_sub_data", 32'(pop_d[1]), 32'(4'h7));
      chk("ovf_sub_flags", 32'(pop_f[1]), 32'(3'b010));
      chk("ovf_xor_data", 32'(pop_d[2]), 32'(4'h0));
      chk("ovf_xor_flags", 32'(pop_f[2]), 32'(3'b100));
    end

    // Backpressure
    pop_d.delete(); pop_f.delete();
    rsp_ready = 1'b0;
    send(2'b10, 4'hF, 4'hF);
    send(2'b10, 4'h0, 4'h0);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_a = 4'hA; cmd_b = 4'h5;
    for (int i = 0; i < 4; i++) begin
      tick(acc);
      chk("bp_held", 32'(acc), 32'(0));
    end
    rsp_ready = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    chk("bp_third_accept", 32'(acc), 32'(1));
    cmd_valid = 1'b0;
    drain();
    chk("bp_count", 32'(pop_d.size()), 32'(3));
    if (pop_d.size() == 3) begin
      chk("bp_data0", 32'(pop_d[0]), 32'(4'h0));
      chk("bp_data1", 32'(pop_d[1]), 32'(4'hF));
      chk("bp_data2", 32'(pop_d[2]), 32'(4'hF));
    end

    // Streaming random ops, consumer always ready
    pop_d.delete(); pop_f.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++)
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    drain();
    chk("stream_count", 32'(pop_d.size()), 32'(16));

    // Random ops with a randomly stalling consumer
    pop_d.delete(); pop_f.delete();
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++)
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    rand_rdy = 1'b0;
    drain();
    chk("rand_count", 32'(pop_d.size()), 32'(20));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
